// File: rtl/local_port_inject_arbiter.sv
// local_port_inject_arbiter
//   Round-robin arbiter that shares one router Local input port between
//   NUM_REQ traffic injectors. The winner's packet is latched and presented
//   to the router through the ReqDnStr/GntDnStr handshake. When the router
//   grants, the winning injector gets a one-cycle GntUp pulse.
//
// Optional feature macro: INJ_ARB_STATS_EN
//   defined   -> per-requester saturating grant counters on GntCount,
//                ClrStats synchronously zeroes them (clear beats increment)
//   undefined -> GntCount tied to zero, ClrStats ignored
//
// Ports
//   clk        in   clock, all state updates on posedge
//   reset      in   asynchronous active-low reset
//   ReqUp      in   [NUM_REQ]            bit i = injector i requests
//   PacketUp   in   [NUM_REQ*dataWidth]  injector i packet at [i*dataWidth +: dataWidth]
//   GntUp      out  [NUM_REQ]            one-hot grant pulse to the winning injector
//   ReqDnStr   out  request to router Local port
//   GntDnStr   in   grant from router Local port
//   DnStrFull  in   router Local FIFO full
//   PacketOut  out  [dataWidth]          latched packet of the current winner
//   ClrStats   in   synchronous clear of grant counters
//   GntCount   out  [NUM_REQ*CNT_W]      per-requester grant counts

module local_port_inject_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned PTR_W     = 2,
    parameter int unsigned dataWidth = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           ReqUp,
    input  logic [NUM_REQ*dataWidth-1:0] PacketUp,
    output logic [NUM_REQ-1:0]           GntUp,
    output logic                         ReqDnStr,
    input  logic                         GntDnStr,
    input  logic                         DnStrFull,
    output logic [dataWidth-1:0]         PacketOut,
    input  logic                         ClrStats,
    output logic [NUM_REQ*CNT_W-1:0]     GntCount
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_GRANT = 2'd1,
        RELEASE    = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   last;
    logic [PTR_W-1:0]   sel;

    logic               winValid;
    logic [PTR_W-1:0]   winIdx;
    logic [dataWidth-1:0] winPacket;

    // Round-robin scan starting just after the last winner. The loop runs from
    // the lowest priority position down to the highest so that the final
    // assignment is the highest-priority requester. Wrap is at NUM_REQ, not
    // at 2^PTR_W, so non-power-of-two requester counts stay fair.
    always_comb begin
        winValid  = 1'b0;
        winIdx    = '0;
        winPacket = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            int idx;
            idx = int'(last) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (ReqUp[idx]) begin
                winValid  = 1'b1;
                winIdx    = PTR_W'(idx);
                winPacket = PacketUp[idx*int'(dataWidth) +: dataWidth];
            end
        end
    end

    // Handshake FSM; every output is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ReqDnStr  <= 1'b0;
            GntUp     <= '0;
            PacketOut <= '0;
            last      <= PTR_W'(NUM_REQ - 1);
            sel       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    GntUp <= '0;
                    // A full router FIFO blocks arbitration and leaves the pointer alone.
                    if (winValid && !DnStrFull) begin
                        PacketOut <= winPacket;
                        sel       <= winIdx;
                        ReqDnStr  <= 1'b1;
                        state     <= WAIT_GRANT;
                    end
                end
                WAIT_GRANT: begin
                    // Request is committed: ReqUp and DnStrFull are not looked at here.
                    if (GntDnStr) begin
                        ReqDnStr <= 1'b0;
                        GntUp    <= NUM_REQ'(1) << sel;
                        last     <= sel;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    GntUp <= '0;
                    state <= IDLE;
                end
                default: begin
                    GntUp    <= '0;
                    ReqDnStr <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef INJ_ARB_STATS_EN
    logic [NUM_REQ*CNT_W-1:0] gntCountQ;

    // Saturating per-requester grant counters, bumped on each GntUp pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gntCountQ <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (ClrStats) begin
                    gntCountQ[i*int'(CNT_W) +: CNT_W] <= '0;
                end else if (GntUp[i] &&
                             (gntCountQ[i*int'(CNT_W) +: CNT_W] != {CNT_W{1'b1}})) begin
                    gntCountQ[i*int'(CNT_W) +: CNT_W] <=
                        gntCountQ[i*int'(CNT_W) +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign GntCount = gntCountQ;
`else
    logic unusedClrStats;

    assign unusedClrStats = ClrStats;
    assign GntCount       = '0;
`endif

    // Structural invariants of the handshake.
    gntOneHot: assert property (@(posedge clk) disable iff (!reset) $onehot0(GntUp));
    reqOnlyWaiting: assert property (@(posedge clk) disable iff (!reset)
                                     ReqDnStr == (state == WAIT_GRANT));
    gntOnlyRelease: assert property (@(posedge clk) disable iff (!reset)
                                     (GntUp != '0) == (state == RELEASE));

endmodule

// File: tb/tb_local_port_inject_arbiter.sv
module tb_local_port_inject_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DW      = 32;
    localparam int unsigned CW      = 16;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_REQ-1:0]      ReqUp = '0;
    logic [NUM_REQ*DW-1:0]   PacketUp;
    logic [NUM_REQ-1:0]      GntUp;
    logic                    ReqDnStr;
    logic                    GntDnStr = 1'b0;
    logic                    DnStrFull = 1'b0;
    logic [DW-1:0]           PacketOut;
    logic                    ClrStats = 1'b0;
    logic [NUM_REQ*CW-1:0]   GntCount;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] pkt [NUM_REQ];

    local_port_inject_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .PTR_W    (2),
        .dataWidth(DW),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ReqUp    (ReqUp),
        .PacketUp (PacketUp),
        .GntUp    (GntUp),
        .ReqDnStr (ReqDnStr),
        .GntDnStr (GntDnStr),
        .DnStrFull(DnStrFull),
        .PacketOut(PacketOut),
        .ClrStats (ClrStats),
        .GntCount (GntCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         delay;
        logic [3:0] expGnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Hold reset for two cycles, checking outputs stay at reset values.
    task automatic doReset(input logic [3:0] reqDuring);
        @(negedge clk);
        ReqUp    = reqDuring;
        GntDnStr = 1'b0;
        reset    = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_reqdn", 32'(ReqDnStr), 32'd0);
            chk("rst_gntup", 32'(GntUp), 32'd0);
            chk("rst_pkt", PacketOut, 32'd0);
        end
        reset = 1'b1;
        ReqUp = '0;
    endtask

    // One full handshake, entered and left at a negedge with the FSM in IDLE.
    task automatic doTxn(input logic [3:0] req, input int delay,
                         input logic [3:0] expGnt, input logic clr);
        logic [DW-1:0] expPkt;
        expPkt = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (expGnt[i]) expPkt = pkt[i];
        end
        ReqUp     = req;
        DnStrFull = 1'b0;
        GntDnStr  = 1'b0;
        @(negedge clk);
        chk("txn_reqdn_rise", 32'(ReqDnStr), 32'd1);
        chk("txn_pkt", PacketOut, expPkt);
        chk("txn_no_early_gnt", 32'(GntUp), 32'd0);
        ReqUp = ~req;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("txn_reqdn_hold", 32'(ReqDnStr), 32'd1);
            chk("txn_pkt_stable", PacketOut, expPkt);
        end
        ReqUp    = req;
        GntDnStr = 1'b1;
        @(negedge clk);
        chk("txn_gntup", 32'(GntUp), 32'(expGnt));
        chk("txn_reqdn_fall", 32'(ReqDnStr), 32'd0);
        GntDnStr = 1'b0;
        ReqUp    = req & ~expGnt;
        ClrStats = clr;
        @(negedge clk);
        chk("txn_gnt_pulse_end", 32'(GntUp), 32'd0);
        chk("txn_reqdn_idle", 32'(ReqDnStr), 32'd0);
        ClrStats = 1'b0;
        ReqUp    = '0;
    endtask

    vec_t       vecs [10];
    logic [3:0] rrSeq [5];
    logic [CW-1:0] expCnt5;

    initial begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            pkt[i] = 32'hA5A5_0000 + 32'(i + 1);
            PacketUp[i*DW +: DW] = pkt[i];
        end

        // Expected winners hand-derived from the pointer left by the previous row.
        vecs[0] = '{4'b0100, 2, 4'b0100};  // last 3 -> 2
        vecs[1] = '{4'b0011, 0, 4'b0001};  // scan 3,0
        vecs[2] = '{4'b0011, 1, 4'b0010};  // scan 1
        vecs[3] = '{4'b1001, 0, 4'b1000};  // scan 2,3
        vecs[4] = '{4'b1010, 3, 4'b0010};  // wrap: scan 0,1
        vecs[5] = '{4'b0010, 0, 4'b0010};  // sole requester again
        vecs[6] = '{4'b0001, 0, 4'b0001};
        vecs[7] = '{4'b1111, 1, 4'b0010};
        vecs[8] = '{4'b1101, 0, 4'b0100};  // scan 2
        vecs[9] = '{4'b0011, 0, 4'b0001};  // scan 3,0

        rrSeq[0] = 4'b0001; rrSeq[1] = 4'b0010; rrSeq[2] = 4'b0100;
        rrSeq[3] = 4'b1000; rrSeq[4] = 4'b0001;

        #3 reset = 1'b0;
        doReset(4'b1111);

        for (int v = 0; v < 10; v++) begin
            doTxn(vecs[v].req, vecs[v].delay, vecs[v].expGnt, 1'b0);
        end

        // Continuous requests with an echoed downstream grant.
        doReset(4'b0000);
        begin
            int gcount;
            int lastCyc;
            gcount  = 0;
            lastCyc = -1;
            ReqUp   = 4'b1111;
            for (int c = 0; c < 30 && gcount < 5; c++) begin
                @(negedge clk);
                if (GntUp != '0) begin
                    chk("rr_order", 32'(GntUp), 32'(rrSeq[gcount]));
                    if (lastCyc >= 0) chk("rr_spacing", 32'(c - lastCyc), 32'd3);
                    lastCyc = c;
                    gcount++;
                end
                GntDnStr = ReqDnStr;
            end
            chk("rr_count", 32'(gcount), 32'd5);
            ReqUp    = '0;
            GntDnStr = 1'b0;
            @(negedge clk);
        end

        // Downstream full blocks arbitration but not a committed request.
        doReset(4'b0000);
        ReqUp     = 4'b0011;
        DnStrFull = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_block", 32'(ReqDnStr), 32'd0);
        end
        DnStrFull = 1'b0;
        @(negedge clk);
        chk("full_release_req", 32'(ReqDnStr), 32'd1);
        chk("full_release_pkt", PacketOut, pkt[0]);
        DnStrFull = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("full_in_wait", 32'(ReqDnStr), 32'd1);
        end
        GntDnStr = 1'b1;
        @(negedge clk);
        chk("full_gnt", 32'(GntUp), 32'b0001);
        GntDnStr  = 1'b0;
        ReqUp     = '0;
        DnStrFull = 1'b0;
        @(negedge clk);
        chk("full_gnt_end", 32'(GntUp), 32'd0);

        // Asynchronous reset mid-handshake; pointer is 0 here, reset restores 3.
        ReqUp = 4'b0010;
        @(negedge clk);
        chk("arst_pre_req", 32'(ReqDnStr), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_reqdn", 32'(ReqDnStr), 32'd0);
        chk("arst_pkt", PacketOut, 32'd0);
        @(negedge clk);
        chk("arst_no_gnt", 32'(GntUp), 32'd0);
        reset = 1'b1;
        doTxn(4'b1111, 0, 4'b0001, 1'b0);

        // Downstream grant outside WAIT_GRANT does nothing.
        ReqUp    = '0;
        GntDnStr = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_gnt_ignored", 32'(GntUp), 32'd0);
            chk("idle_no_req", 32'(ReqDnStr), 32'd0);
        end
        GntDnStr = 1'b0;

        // Grant statistics.
`ifdef INJ_ARB_STATS_EN
        expCnt5 = CW'(5);
`else
        expCnt5 = '0;
`endif
        ClrStats = 1'b1;
        @(negedge clk);
        ClrStats = 1'b0;
        chk("stats_cleared", 32'(GntCount[1*CW +: CW]), 32'd0);
        for (int g = 0; g < 5; g++) begin
            doTxn(4'b0010, 0, 4'b0010, 1'b0);
        end
        chk("stats_cnt1", 32'(GntCount[1*CW +: CW]), 32'(expCnt5));
        chk("stats_cnt0", 32'(GntCount[0*CW +: CW]), 32'd0);
        doTxn(4'b0010, 0, 4'b0010, 1'b1);
        chk("stats_clr_wins", 32'(GntCount[1*CW +: CW]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
